// File: rtl/sentinel_pkg.sv
// Shared definitions for the Sentinel Lock key path: FSM states, key constants
// and the hex segment codes used by the gate's status display.
package sentinel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESENT,
    ST_EVAL,
    ST_GRANTED,
    ST_LOCKOUT
  } state_t;

  localparam logic [7:0] AUTH_KEY     = 8'hB6;
  localparam logic [7:0] IDLE_KEY_DEF = 8'h00;

  // Active-high segments ordered {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_code(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b0111111;
      4'h1: seg = 7'b0000110;
      4'h2: seg = 7'b1011011;
      4'h3: seg = 7'b1001111;
      4'h4: seg = 7'b1100110;
      4'h5: seg = 7'b1101101;
      4'h6: seg = 7'b1111101;
      4'h7: seg = 7'b0000111;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1101111;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b1111100;
      4'hC: seg = 7'b0111001;
      4'hD: seg = 7'b1011110;
      4'hE: seg = 7'b1111001;
      default: seg = 7'b1110001;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sentinel_debounce.sv
// Bus-wide debouncer: the output follows the input only after it has been
// identical on every bit for DEBOUNCE_CYCLES consecutive clocks.
module sentinel_debounce #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] stable
);

  localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ARM  = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic [WIDTH-1:0] cand;
  logic [CNT_W-1:0] cnt;

  // Any bit differing from the candidate restarts the window for the whole bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand   <= '0;
      cnt    <= '0;
      stable <= '0;
    end else if (din != cand) begin
      cand <= din;
      cnt  <= '0;
    end else if (cnt != CNT_LAST) begin
      cnt <= cnt + CNT_W'(1);
      if (cnt == CNT_ARM) stable <= cand;
    end
  end

endmodule

// File: rtl/sentinel_key_conditioner.sv
// Conditions raw DIP switches and a commit button into a held key for the
// Sentinel gate, evaluates the gate's verdict and enforces a retry lockout.
module sentinel_key_conditioner
  import sentinel_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned MAX_FAILS       = 3,
  parameter int unsigned LOCKOUT_CYCLES  = 10000000,
  parameter logic [7:0]  IDLE_KEY        = IDLE_KEY_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               ena,
  input  logic [7:0]                         sw_in,
  input  logic                               commit_btn,
  input  logic                               auth_ok,
  output logic [7:0]                         key_out,
  output logic                               key_valid,
  output logic                               lockout,
  output logic [$clog2(MAX_FAILS+1)-1:0]     fail_cnt
);

  localparam int unsigned FAIL_W  = $clog2(MAX_FAILS + 1);
  localparam int unsigned TIMER_W = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [FAIL_W-1:0]  FAIL_LAST  = FAIL_W'(MAX_FAILS - 1);
  localparam logic [FAIL_W-1:0]  FAIL_MAX   = FAIL_W'(MAX_FAILS);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);

  logic [7:0]         sw_s1, sw_s2, sw_stable;
  logic               btn_s1, btn_s2, btn_stable, btn_prev;
  logic               commit_c;
  logic [TIMER_W-1:0] lock_timer;
  state_t             state;

  // Two-flop synchronisers for the asynchronous switch and button inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      sw_s1  <= sw_in;
      sw_s2  <= sw_s1;
      btn_s1 <= commit_btn;
      btn_s2 <= btn_s1;
    end
  end

  sentinel_debounce #(
    .WIDTH           (8),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_db (
    .clk    (clk),
    .rst    (rst),
    .din    (sw_s2),
    .stable (sw_stable)
  );

  sentinel_debounce #(
    .WIDTH           (1),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_db (
    .clk    (clk),
    .rst    (rst),
    .din    (btn_s2),
    .stable (btn_stable)
  );

  always_ff @(posedge clk) begin
    if (rst) btn_prev <= 1'b0;
    else     btn_prev <= btn_stable;
  end

  assign commit_c = btn_stable & ~btn_prev;

  // Key presentation / evaluation / lockout sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      key_out    <= IDLE_KEY;
      key_valid  <= 1'b0;
      lockout    <= 1'b0;
      fail_cnt   <= '0;
      lock_timer <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ena && commit_c) begin
            key_out   <= sw_stable;
            key_valid <= 1'b1;
            state     <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (!ena) begin
            key_out   <= IDLE_KEY;
            key_valid <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            state <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (!ena) begin
            key_out   <= IDLE_KEY;
            key_valid <= 1'b0;
            state     <= ST_IDLE;
          end else if (auth_ok) begin
            fail_cnt <= '0;
            state    <= ST_GRANTED;
          end else if (fail_cnt < FAIL_LAST) begin
            fail_cnt  <= fail_cnt + FAIL_W'(1);
            key_out   <= IDLE_KEY;
            key_valid <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            fail_cnt   <= FAIL_MAX;
            key_out    <= IDLE_KEY;
            key_valid  <= 1'b0;
            lockout    <= 1'b1;
            lock_timer <= TIMER_LOAD;
            state      <= ST_LOCKOUT;
          end
        end
        ST_GRANTED: begin
          if (!ena || (sw_stable != key_out)) begin
            key_out   <= IDLE_KEY;
            key_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_LOCKOUT: begin
          // ena is deliberately ignored so power cycling cannot shorten the penalty.
          if (lock_timer == '0) begin
            fail_cnt <= '0;
            lockout  <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            lock_timer <= lock_timer - TIMER_W'(1);
          end
        end
        default: begin
          key_out   <= IDLE_KEY;
          key_valid <= 1'b0;
          lockout   <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
